// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide responder; fixed-latency multiply,
// radix-2 restoring divide, results returned on hi/lo with a registered ok.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_PASS  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4
  } decoded_op_t;
endpackage

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        en,
  input  logic        first,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  decoded_op_t op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ok,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_n;
  decoded_op_t op_r, m_op;
  logic [5:0]  cnt;
  logic [31:0] opa, opb, dvs, rem, quo, abs_a, abs_b, m_a, m_b;
  logic [32:0] trial, diff;
  logic [63:0] ext_a, ext_b, prod, div_res, res;
  logic        accept, in_mul, in_div, mul_done, div_done, m_signed, enter_done;

  assign accept   = en & (state == IDLE | first) & ~flush;
  assign in_mul   = op == OP_MULT | op == OP_MULTU;
  assign in_div   = op == OP_DIV | op == OP_DIVU;
  assign mul_done = state == MUL & cnt == 6'(MUL_STAGES - 1);
  assign div_done = state == DIV & cnt == 6'd32;
  assign busy     = state == MUL | state == DIV;

  // One shared multiplier: fed from the inputs on accept (single-stage case), else from latched operands.
  assign m_op     = accept ? op : op_r;
  assign m_a      = accept ? srca : opa;
  assign m_b      = accept ? srcb : opb;
  assign m_signed = m_op == OP_MULT;
  assign ext_a    = {{32{m_signed & m_a[31]}}, m_a};
  assign ext_b    = {{32{m_signed & m_b[31]}}, m_b};
  assign prod     = ext_a * ext_b;

  assign abs_a = (op == OP_DIV & srca[31]) ? -srca : srca;
  assign abs_b = (op == OP_DIV & srcb[31]) ? -srcb : srcb;
  assign trial = {rem, quo[31]};
  assign diff  = trial - {1'b0, dvs};

  assign div_res = (opb == 32'd0) ? {opa, 32'hFFFF_FFFF} :
                   (op_r == OP_DIV) ? {(opa[31] ? -rem : rem), ((opa[31] ^ opb[31]) ? -quo : quo)} :
                   {rem, quo};
  assign res = (accept | state == MUL) ? ((m_op == OP_MULT | m_op == OP_MULTU) ? prod : 64'd0) : div_res;
  assign enter_done = state_n == DONE & (accept | state != DONE);

  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (accept) state_n = in_mul ? (MUL_STAGES == 1 ? DONE : MUL) : in_div ? DIV : DONE;
    else if (!en) state_n = IDLE;
    else if (mul_done | div_done) state_n = DONE;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      op_r  <= OP_PASS;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      hi    <= '0;
      lo    <= '0;
      ok    <= 1'b0;
    end else begin
      state <= state_n;
      ok    <= state_n == DONE;
      if (accept) begin
        op_r <= op;
        opa  <= srca;
        opb  <= srcb;
        dvs  <= abs_b;
        quo  <= abs_a;
        rem  <= '0;
        cnt  <= in_mul ? 6'd1 : 6'd0;
      end else if (state == DIV & cnt < 6'd32) begin
        rem <= diff[32] ? trial[31:0] : diff[31:0];
        quo <= {quo[30:0], ~diff[32]};
        cnt <= cnt + 6'd1;
      end else if (state == MUL) cnt <= cnt + 6'd1;
      if (enter_done) {hi, lo} <= res;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int MS = 2;

  logic        clk = 0, resetn = 0, flush = 0, en = 0, first = 0;
  logic [31:0] srca = 0, srcb = 0, hi, lo;
  decoded_op_t op = OP_PASS;
  logic        ok, busy;
  int          nchk = 0, nfail = 0;
  logic [63:0] last_e = 0;

  muldiv_unit #(.MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .en(en), .first(first),
    .srca(srca), .srcb(srcb), .op(op), .hi(hi), .lo(lo), .ok(ok), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input decoded_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int x, y;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    x = $signed(a); y = $signed(b);
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(x % y), 32'(x / y)};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int latency(input decoded_op_t o);
    return (o == OP_MULT || o == OP_MULTU) ? MS : (o == OP_DIV || o == OP_DIVU) ? 34 : 1;
  endfunction

  task automatic start(input decoded_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    en = 1; first = 1; op = o; srca = a; srcb = b;
    @(posedge clk);
    #1 first = 0;
  endtask

  task automatic run_op(input decoded_op_t o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] e;
    int cyc;
    e = model(o, a, b);
    start(o, a, b);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ok && cyc < 60);
    chk({tag, " latency"}, 64'(cyc), 64'(latency(o)));
    chk({tag, " result"}, {hi, lo}, e);
    @(negedge clk);
    chk({tag, " hold"}, {ok, hi, lo}, {1'b1, e});
    en = 0;
    @(negedge clk);
    chk({tag, " release"}, {ok, hi, lo}, {1'b0, e});
    last_e = e;
  endtask

  initial begin
    logic stale;
    #12;
    chk("reset", {ok, busy, hi, lo}, 66'd0);
    resetn = 1;

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(OP_DIVU, 32'd100, 32'd0, "divu_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_negb");
    run_op(decoded_op_t'(3'd6), 32'd5, 32'd9, "pass");

    // Flush in cycle 10 of a divide: no result, prior hi/lo kept.
    start(OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    chk("flush busy", {busy, ok}, 2'b10);
    flush = 1;
    @(negedge clk);
    chk("flush idle", {busy, ok, hi, lo}, {2'b00, last_e});
    flush = 0; en = 0;
    repeat (40) @(negedge clk);
    chk("flush quiet", {ok, hi, lo}, {1'b0, last_e});

    // Asynchronous reset mid-divide clears outputs immediately.
    run_op(OP_MULTU, 32'd6, 32'd7, "pre_rst");
    start(OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    resetn = 0;
    #1 chk("async rst", {ok, busy, hi, lo}, 66'd0);
    en = 0;
    @(negedge clk);
    resetn = 1;
    last_e = 0;

    // Back-to-back: MULTU re-accepted in cycle 5 of a DIVU.
    start(OP_DIVU, 32'd9, 32'd4);
    repeat (5) @(negedge clk);
    first = 1; op = OP_MULTU; srca = 32'd3; srcb = 32'd5;
    @(posedge clk);
    #1 first = 0;
    @(negedge clk);
    chk("b2b c6", {ok, busy}, 2'b01);
    @(negedge clk);
    chk("b2b c7", {ok, hi, lo}, {1'b1, 64'd15});
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if ({ok, hi, lo} !== {1'b1, 64'd15}) stale = 1;
    end
    chk("b2b stale", 64'(stale), 64'd0);
    en = 0;
    @(negedge clk);
    last_e = 64'd15;

    // en dropped during multiply aborts it.
    start(OP_MULT, 32'd5, 32'd7);
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd1);
    en = 0;
    @(negedge clk);
    chk("abort idle", {ok, busy, hi, lo}, {2'b00, last_e});
    repeat (3) @(negedge clk);
    chk("abort quiet", {ok, hi, lo}, {1'b0, last_e});

    for (int i = 0; i < 40; i++) begin
      decoded_op_t o;
      logic [31:0] a, b;
      int r;
      r = $urandom_range(0, 7);
      o = decoded_op_t'(3'(r));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(o, a, b, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
